// File: rtl/inst_rom.sv
// Instruction ROM with a combinational fetch port and a byte-serial program load port.
// Define ROM_LOAD_CHECKSUM_EN to accumulate a 32-bit sum of every word written by a load.
module inst_rom #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           rom_chip_enable,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_data,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   load_word_count,
    output logic [31:0]           load_checksum
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [1:0]            r_cnt;
    logic [31:0]           r_asm;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_overflow;
    logic                  w_write;
    logic [31:0]           w_word;
    logic                  w_addr_hi_zero;
    logic                  w_unused;

    assign w_accept   = (r_state == S_LOAD) && load_valid && !load_start;
    assign w_complete = w_accept && ((r_cnt == 2'd3) || load_last);
    assign w_overflow = w_complete && (r_ptr == PTR_FULL);
    assign w_write    = w_complete && !w_overflow && !reset;

    // Merge the incoming byte into its big-endian lane; unfilled low lanes stay zero.
    always_comb begin
        w_word = r_asm;
        case (r_cnt)
            2'd0:    w_word[31:24] = load_byte;
            2'd1:    w_word[23:16] = load_byte;
            2'd2:    w_word[15:8]  = load_byte;
            default: w_word[7:0]   = load_byte;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_error <= 1'b0;
        end else if (load_start) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_complete) begin
                            r_cnt <= '0;
                            r_asm <= '0;
                            if (w_overflow) begin
                                r_error <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_ptr <= r_ptr + 1'b1;
                                if (load_last)
                                    r_state <= S_DONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_asm <= w_word;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset: contents survive reset and are only replaced by a load.
    always_ff @(posedge clock) begin
        if (w_write)
            r_mem[r_ptr[ADDR_WIDTH-1:0]] <= w_word;
    end

`ifdef ROM_LOAD_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clock) begin
        if (reset || load_start)
            r_checksum <= '0;
        else if (w_write)
            r_checksum <= r_checksum + w_word;
    end

    assign load_checksum = r_checksum;
`else
    assign load_checksum = '0;
`endif

    assign load_ready      = (r_state == S_LOAD);
    assign load_busy       = (r_state == S_LOAD);
    assign load_done       = (r_state == S_DONE);
    assign load_error      = r_error;
    assign load_word_count = r_ptr;

    // Fetch returns NOP while disabled, out of range, or while the array is being rewritten.
    assign w_addr_hi_zero = (rom_addr[31:ADDR_WIDTH+2] == '0);
    assign rom_data = ((rom_chip_enable != 32'd0) && w_addr_hi_zero && (r_state != S_LOAD))
                      ? r_mem[rom_addr[ADDR_WIDTH+1:2]] : 32'd0;

    assign w_unused = ^rom_addr[1:0];

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: load port sequencing, fetch gating, overflow, restart and reset.
module tb_inst_rom;

    localparam int AW = 10;

    logic          clock;
    logic          reset;
    logic [31:0]   rom_chip_enable;
    logic [31:0]   rom_addr;
    logic [31:0]   rom_data;
    logic          load_start;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_last;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   load_word_count;
    logic [31:0]   load_checksum;

    int n_total;
    int n_bad;

    inst_rom #(.ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .rom_chip_enable (rom_chip_enable),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .load_start      (load_start),
        .load_valid      (load_valid),
        .load_byte       (load_byte),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_error      (load_error),
        .load_word_count (load_word_count),
        .load_checksum   (load_checksum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] ce, input logic [31:0] addr,
                         input logic [31:0] exp);
        rom_chip_enable = ce;
        rom_addr        = addr;
        #1;
        chk(tag, rom_data, exp);
    endtask

    function automatic logic [7:0] pat(input int j);
        return 8'(j ^ (j >> 8));
    endfunction

    function automatic logic [31:0] wordpat(input int i);
        return {pat(4*i), pat(4*i+1), pat(4*i+2), pat(4*i+3)};
    endfunction

    logic [31:0] exp_sum;

    initial begin
        n_total         = 0;
        n_bad           = 0;
        reset           = 1'b1;
        rom_chip_enable = '0;
        rom_addr        = '0;
        load_start      = 1'b0;
        load_valid      = 1'b0;
        load_byte       = '0;
        load_last       = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy",  32'(load_busy),  32'd0);
        chk("rst_done",  32'(load_done),  32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        chk("rst_count", 32'(load_word_count), 32'd0);
        chk("rst_csum",  load_checksum, 32'd0);

        // single word load
        start_load();
        chk("t1_ready", 32'(load_ready), 32'd1);
        chk("t1_busy",  32'(load_busy),  32'd1);
        send_byte(8'h24, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b1);
        chk("t1_done",  32'(load_done), 32'd1);
        chk("t1_count", 32'(load_word_count), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(load_done), 32'd0);
        fetch("t1_fetch0", 32'd1, 32'h0000_0000, 32'h2401_0005);
        fetch("t1_fetch2", 32'd1, 32'h0000_0002, 32'h2401_0005);

        // two words, padded tail
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        chk("t2_done",  32'(load_done), 32'd1);
        chk("t2_count", 32'(load_word_count), 32'd2);
        tick();
`ifdef ROM_LOAD_CHECKSUM_EN
        exp_sum = 32'h1122_3344 + 32'h5566_0000;
`else
        exp_sum = 32'd0;
`endif
        chk("t2_csum",  load_checksum, exp_sum);
        chk("t2_count_hold", 32'(load_word_count), 32'd2);
        fetch("t2_mem0", 32'd1, 32'h0000_0000, 32'h1122_3344);
        fetch("t2_mem1", 32'd1, 32'h0000_0004, 32'h5566_0000);
        fetch("t3_ce0",  32'd0, 32'h0000_0000, 32'd0);
        fetch("t3_ce_hi", 32'h8000_0000, 32'h0000_0000, 32'h1122_3344);
        fetch("t3_range", 32'd1, 32'h0000_1000, 32'd0);

        // overflow stream; fetch is masked during LOAD
        start_load();
        fetch("t3_inload", 32'd1, 32'h0000_0000, 32'd0);
        load_valid = 1'b1;
        load_last  = 1'b0;
        for (int j = 0; j < 4*1024+4; j++) begin
            load_byte = pat(j);
            tick();
            if (j == 4*1024+2)
                chk("t4_pre_done", 32'(load_done), 32'd0);
        end
        load_valid = 1'b0;
        chk("t4_done",  32'(load_done), 32'd1);
        chk("t4_error", 32'(load_error), 32'd1);
        chk("t4_count", 32'(load_word_count), 32'd1024);
        chk("t4_ready", 32'(load_ready), 32'd0);
        tick();
        chk("t4_done_pulse", 32'(load_done), 32'd0);
        chk("t4_error_hold", 32'(load_error), 32'd1);
        fetch("t4_mem0",    32'd1, 32'h0000_0000, wordpat(0));
        fetch("t4_mem500",  32'd1, 32'd500*4,     wordpat(500));
        fetch("t4_mem1023", 32'd1, 32'd1023*4,    wordpat(1023));

        // valid toggling every cycle
        start_load();
        chk("t5_error_clr", 32'(load_error), 32'd0);
        for (int j = 0; j < 8; j++) begin
            send_byte(8'hA0 + 8'(j), (j == 7) ? 1'b1 : 1'b0);
            if (j == 7)
                chk("t5_done", 32'(load_done), 32'd1);
            tick();
        end
        chk("t5_count", 32'(load_word_count), 32'd2);
        fetch("t5_mem0", 32'd1, 32'h0000_0000, 32'hA0A1_A2A3);
        fetch("t5_mem1", 32'd1, 32'h0000_0004, 32'hA4A5_A6A7);

        // restart after two bytes discards them
        start_load();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        start_load();
        chk("t5r_count", 32'(load_word_count), 32'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        chk("t5r_count1", 32'(load_word_count), 32'd1);
        tick();
        fetch("t5r_mem0", 32'd1, 32'h0000_0000, 32'h0102_0304);
        fetch("t5r_mem1", 32'd1, 32'h0000_0004, 32'hA4A5_A6A7);

        // reset mid-load
        start_load();
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hE2, 1'b0);
        chk("t6_count_pre", 32'(load_word_count), 32'd1);
        do_reset();
        chk("t6_count", 32'(load_word_count), 32'd0);
        chk("t6_busy",  32'(load_busy),  32'd0);
        chk("t6_ready", 32'(load_ready), 32'd0);
        chk("t6_done",  32'(load_done),  32'd0);
        chk("t6_csum",  load_checksum, 32'd0);
        fetch("t6_mem0", 32'd1, 32'h0000_0000, 32'hC0C1_C2C3);
        fetch("t6_mem1", 32'd1, 32'h0000_0004, 32'hA4A5_A6A7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
